// File: rtl/rr_fifo_arbiter_param.sv
`default_nettype none
// ============================================================================
// rr_fifo_arbiter_param : per-channel FIFOs drained round-robin into one
// registered valid/ready output stage.                      Rev 1.0
// ============================================================================
module rr_fifo_arbiter_param #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int NCH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           wen,
  input  logic [NCH*DW-1:0]        din,
  output logic [NCH-1:0]           full,
  output logic [NCH-1:0]           ovf_err,
  output logic [DW-1:0]            dout,
  output logic [$clog2(NCH)-1:0]   src,
  output logic                     valid,
  input  logic                     ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(NCH);

  localparam logic [CW-1:0] c_depth_cnt = CW'(DEPTH);

  logic [NCH-1:0]    nonempty;
  logic [NCH-1:0]    pop;
  logic [NCH*DW-1:0] head_data;

  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] grant;
  logic          any_ne;
  logic          load;
  logic [DW-1:0] dout_sel;

  logic [DW-1:0] dout_q;
  logic [SW-1:0] src_q;
  logic          valid_q;

  // (base + off) mod NCH without a divider; base < NCH and off < NCH
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] base, input int off);
    logic [SW:0] s;
    s = {1'b0, base} + (SW+1)'(off);
    if (s >= (SW+1)'(NCH)) s = s - (SW+1)'(NCH);
    return s[SW-1:0];
  endfunction

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      logic [DW-1:0] mem_q [DEPTH];
      logic [AW-1:0] head_q, head_d;
      logic [AW-1:0] tail_q, tail_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          ovf_q;
      logic          wr_ok;

      // Acceptance uses the start-of-cycle count, so a same-cycle pop does not free a slot
      assign wr_ok = wen[k] && (cnt_q < c_depth_cnt);

      always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (wr_ok)  tail_d = tail_q + AW'(1);
        if (pop[k]) head_d = head_q + AW'(1);
        case ({wr_ok, pop[k]})
          2'b10:   cnt_d = cnt_q + CW'(1);
          2'b01:   cnt_d = cnt_q - CW'(1);
          default: cnt_d = cnt_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          head_q <= '0;
          tail_q <= '0;
          cnt_q  <= '0;
          ovf_q  <= 1'b0;
        end else begin
          head_q <= head_d;
          tail_q <= tail_d;
          cnt_q  <= cnt_d;
          ovf_q  <= wen[k] && !(cnt_q < c_depth_cnt);
        end
      end

      always_ff @(posedge clk) begin
        if (wr_ok) mem_q[tail_q] <= din[k*DW +: DW];
      end

      assign nonempty[k]            = (cnt_q != '0);
      assign full[k]                = (cnt_q == c_depth_cnt);
      assign ovf_err[k]             = ovf_q;
      assign head_data[k*DW +: DW]  = mem_q[head_q];
    end
  endgenerate

  // Scan from the highest offset down so the nearest non-empty channel wins
  always_comb begin
    grant  = rr_ptr_q;
    any_ne = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (nonempty[wrap_inc(rr_ptr_q, i)]) begin
        grant  = wrap_inc(rr_ptr_q, i);
        any_ne = 1'b1;
      end
    end
  end

  always_comb begin
    dout_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SW'(i) == grant) dout_sel = head_data[i*DW +: DW];
    end
  end

  assign load     = (!valid_q || ready) && any_ne;
  assign pop      = load ? (NCH'(1) << grant) : '0;
  assign rr_ptr_d = load ? wrap_inc(grant, 1) : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q   <= '0;
      src_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load) begin
        dout_q  <= dout_sel;
        src_q   <= grant;
        valid_q <= 1'b1;
      end else if (ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dout  = dout_q;
  assign src   = src_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_fifo_arbiter_param.sv
`default_nettype none
// Bench for rr_fifo_arbiter_param: queue-based reference model checked every
// cycle under directed scenarios and random traffic.
module tb_rr_fifo_arbiter_param;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;
  localparam int SW    = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              ready = 1'b0;
  logic [NCH-1:0]    wen   = '0;
  logic [NCH*DW-1:0] din   = '0;
  logic [NCH-1:0]    full;
  logic [NCH-1:0]    ovf_err;
  logic [DW-1:0]     dout;
  logic [SW-1:0]     src;
  logic              valid;

  always #5 clk = ~clk;

  rr_fifo_arbiter_param #(.DW(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wen     (wen),
    .din     (din),
    .full    (full),
    .ovf_err (ovf_err),
    .dout    (dout),
    .src     (src),
    .valid   (valid),
    .ready   (ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue per channel plus the visible output register
  logic [DW-1:0]  mq [NCH][$];
  logic           mv   = 1'b0;
  logic [DW-1:0]  md   = '0;
  int             ms   = 0;
  int             mrr  = 0;
  logic [NCH-1:0] movf = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] mfull();
    logic [NCH-1:0] f;
    for (int c = 0; c < NCH; c++) f[c] = (mq[c].size() == DEPTH);
    return f;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    int sz [NCH];
    int g;
    bit found;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      mv = 1'b0; md = '0; ms = 0; mrr = 0; movf = '0;
      return;
    end
    found = 1'b0;
    g = 0;
    for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
    for (int i = 0; i < NCH; i++) begin
      if (!found && sz[(mrr + i) % NCH] > 0) begin
        found = 1'b1;
        g = (mrr + i) % NCH;
      end
    end
    if ((!mv || ready) && found) begin
      md  = mq[g].pop_front();
      ms  = g;
      mv  = 1'b1;
      mrr = (g + 1) % NCH;
    end else if (mv && ready) begin
      mv = 1'b0;
    end
    for (int c = 0; c < NCH; c++) begin
      movf[c] = wen[c] && (sz[c] == DEPTH);
      if (wen[c] && sz[c] < DEPTH) mq[c].push_back(din[c*DW +: DW]);
    end
  endtask

  task automatic step(input logic r, input logic [NCH-1:0] w,
                      input logic [NCH*DW-1:0] d, input logic rn);
    ready = r;
    wen   = w;
    din   = d;
    rst_n = rn;
    model_edge();
    @(posedge clk);
    #1;
    chk("valid",   valid,   mv);
    chk("dout",    dout,    md);
    chk("src",     src,     ms);
    chk("full",    full,    mfull());
    chk("ovf_err", ovf_err, movf);
  endtask

  initial begin
    logic [NCH-1:0] w;
    logic [NCH*DW-1:0] d;

    step(1, '0, '0, 0);
    step(1, '0, '0, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dout",  dout,  0);
    chk("rst_full",  full,  0);

    // Single word latency
    step(1, 4'b0001, 32'h0000_0011, 1);
    step(1, '0, '0, 1);
    chk("t1_valid", valid, 1);
    chk("t1_dout",  dout,  8'h11);
    chk("t1_src",   src,   0);
    step(1, '0, '0, 1);
    chk("t1_idle",  valid, 0);

    // Two words on every channel, round-robin order
    step(0, 4'hF, {8'hD0, 8'hC0, 8'hB0, 8'hA0}, 1);
    step(0, 4'hF, {8'hD1, 8'hC1, 8'hB1, 8'hA1}, 1);
    for (int i = 0; i < 9; i++) step(1, '0, '0, 1);
    chk("t2_drained", valid, 0);

    // Only ch1 and ch3 busy
    for (int i = 0; i < 3; i++) step(0, 4'b1010, {8'(8'h30 + i), 8'h00, 8'(8'h10 + i), 8'h00}, 1);
    for (int i = 0; i < 7; i++) step(1, '0, '0, 1);

    // Overfill ch2
    for (int i = 0; i < 10; i++) step(0, 4'b0100, {8'h00, 8'(8'h40 + i), 16'h0000}, 1);
    step(0, '0, '0, 1);
    chk("t4_full2", full[2], 1);
    for (int i = 0; i < 11; i++) step(1, '0, '0, 1);

    // Backpressure while writing ch0
    step(0, 4'b0001, 32'h0000_0050, 1);
    for (int i = 0; i < 5; i++) step(0, 4'b0001, {24'h0, 8'(8'h51 + i)}, 1);
    for (int i = 0; i < 8; i++) step(1, '0, '0, 1);

    // Reset with words queued
    step(0, 4'b0111, 32'h0063_6261, 1);
    step(0, 4'b0111, 32'h0066_6564, 1);
    step(1, '0, '0, 0);
    chk("t6_valid", valid, 0);
    chk("t6_full",  full,  0);
    for (int i = 0; i < 4; i++) step(1, '0, '0, 1);

    // Random traffic: heavy then light writes, random backpressure, rare resets
    for (int n = 0; n < 2000; n++) begin
      w = NCH'($urandom);
      if (n >= 1000) w = w & NCH'($urandom);
      d = NCH*DW'($urandom);
      step(($urandom_range(0, 3) != 0), w, d, ($urandom_range(0, 249) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
